// File: rtl/bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int unsigned BCD_DIGIT_W = 4;

  // Decimal digit count of 2^bin_w - 1, i.e. ceil(bin_w * log10(2)) with log10(2) ~ 0.30103.
  function automatic int unsigned bcd_digits_for(input int unsigned bin_w);
    int unsigned d;
    d = (bin_w * 30103 + 99999) / 100000;
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of double dabble: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_DIGIT_W'(5)) digit_out = digit_in + BCD_DIGIT_W'(3);
  end

endmodule

// File: rtl/bcd_iter_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per cycle,
// valid/ready handshake on both sides and an overflow flag for truncated results.
module bcd_iter_conv
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [BIN_W-1:0]              data_in,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  conv_state_t      state, state_nxt;
  logic [BIN_W-1:0] bin_sh;
  logic [BCD_W-1:0] bcd_acc;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;
  logic             ovf;
  logic             ovf_bit;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_q;
  logic             ovf_q;
  logic             accept;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit_in  (bcd_acc[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (bcd_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Top bit of the adjusted accumulator falls off on the shift: that is the decimal carry-out.
  assign ovf_bit   = bcd_adj[BCD_W-1];
  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
  assign accept    = en && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en)             state_nxt = SHIFT;
      SHIFT:   if (cnt <= CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // The result is captured into separate registers on the final shift so the
  // outputs keep the previous result while the next conversion runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sh  <= '0;
      bcd_acc <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      bin_sh  <= data_in;
      bcd_acc <= '0;
      ovf     <= 1'b0;
      cnt     <= CNT_INIT;
    end else if (state == SHIFT && cnt != '0) begin
      bin_sh  <= bin_sh << 1;
      bcd_acc <= bcd_shift;
      ovf     <= ovf | ovf_bit;
      cnt     <= cnt - CNT_LAST;
      if (cnt == CNT_LAST) begin
        bcd_q <= bcd_shift;
        ovf_q <= ovf | ovf_bit;
      end
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_iter_conv.sv
// Self-checking bench for bcd_iter_conv: three parameterisations against a decimal reference model.
module tb_bcd_iter_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        en_a = 1'b0, or_a = 1'b0, ir_a, ov_a, of_a;
  logic [7:0]  din_a = '0;
  logic [11:0] bcd_a;
  logic        en_b = 1'b0, or_b = 1'b0, ir_b, ov_b, of_b;
  logic [7:0]  din_b = '0;
  logic [7:0]  bcd_b;
  logic        en_c = 1'b0, or_c = 1'b0, ir_c, ov_c, of_c;
  logic [15:0] din_c = '0;
  logic [19:0] bcd_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_iter_conv #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .data_in(din_a), .in_ready(ir_a),
    .out_valid(ov_a), .out_ready(or_a), .bcd_out(bcd_a), .overflow(of_a));
  bcd_iter_conv #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .data_in(din_b), .in_ready(ir_b),
    .out_valid(ov_b), .out_ready(or_b), .bcd_out(bcd_b), .overflow(of_b));
  bcd_iter_conv #(.BIN_W(16), .DIGITS(5)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .data_in(din_c), .in_ready(ir_c),
    .out_valid(ov_c), .out_ready(or_c), .bcd_out(bcd_c), .overflow(of_c));

  // Reference: take decimal digits by repeated division; anything left over is overflow.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int digits, output logic ovf);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    ovf = (v != 0);
    return r;
  endfunction

  function automatic int bin_w_of(input int id);
    return (id == 2) ? 16 : 8;
  endfunction

  function automatic int digits_of(input int id);
    case (id) 0: return 3; 1: return 2; default: return 5; endcase
  endfunction

  function automatic logic get_ir(input int id);
    case (id) 0: return ir_a; 1: return ir_b; default: return ir_c; endcase
  endfunction

  function automatic logic get_ov(input int id);
    case (id) 0: return ov_a; 1: return ov_b; default: return ov_c; endcase
  endfunction

  function automatic logic get_of(input int id);
    case (id) 0: return of_a; 1: return of_b; default: return of_c; endcase
  endfunction

  function automatic logic [63:0] get_bcd(input int id);
    case (id) 0: return {52'b0, bcd_a}; 1: return {56'b0, bcd_b}; default: return {44'b0, bcd_c}; endcase
  endfunction

  task automatic set_en(input int id, input logic e, input longint unsigned d);
    case (id)
      0: begin en_a = e; din_a = d[7:0]; end
      1: begin en_b = e; din_b = d[7:0]; end
      default: begin en_c = e; din_c = d[15:0]; end
    endcase
  endtask

  task automatic set_or(input int id, input logic r);
    case (id) 0: or_a = r; 1: or_b = r; default: or_c = r; endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept v, measure cycles until out_valid, capture result, optionally stall, then handshake.
  task automatic do_conv(input int id, input longint unsigned v, input int hold,
                         output logic [63:0] bcd, output logic ovf, output int lat, output logic busy);
    int w;
    w = 0;
    while (get_ir(id) !== 1'b1 && w < 200) begin tick(); w++; end
    set_en(id, 1'b1, v);
    tick();
    set_en(id, 1'b0, longint'($urandom));
    busy = get_ir(id);
    lat = 0;
    while (get_ov(id) !== 1'b1 && lat < 200) begin tick(); lat++; end
    bcd = get_bcd(id);
    ovf = get_of(id);
    for (int i = 0; i < hold; i++) tick();
    set_or(id, 1'b1);
    tick();
    set_or(id, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int id = 0; id < 3; id++) begin
      checks++; if (get_ir(id) !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", id, get_ir(id)); end
      checks++; if (get_ov(id) !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", id, get_ov(id)); end
      checks++; if (get_bcd(id) !== 64'h0) begin errors++; $display("FAIL reset_bcd[%0d]: got %h expected 0", id, get_bcd(id)); end
      checks++; if (get_of(id) !== 1'b0) begin errors++; $display("FAIL reset_overflow[%0d]: got %b expected 0", id, get_of(id)); end
    end
  endtask

  task automatic test_max();
    logic [63:0] bcd; logic ovf; int lat; logic busy;
    do_conv(0, 255, 0, bcd, ovf, lat, busy);
    checks++; if (bcd !== 64'h255) begin errors++; $display("FAIL max_bcd: got %h expected 255", bcd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL max_overflow: got %b expected 0", ovf); end
    checks++; if (lat != 8) begin errors++; $display("FAIL max_latency: got %0d expected 8", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL max_busy: in_ready got %b expected 0", busy); end
    checks++; if (ir_a !== 1'b1 || ov_a !== 1'b0) begin errors++; $display("FAIL max_return_idle: in_ready=%b out_valid=%b expected 1/0", ir_a, ov_a); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] bcd, exp; logic ovf, eo; int lat; logic busy;
    for (int v = 0; v < 256; v++) begin
      do_conv(0, longint'(v), 0, bcd, ovf, lat, busy);
      exp = ref_bcd(longint'(v), 3, eo);
      checks++; if (bcd !== exp || ovf !== eo) begin errors++; $display("FAIL exh_result[%0d]: got %h/%b expected %h/%b", v, bcd, ovf, exp, eo); end
      checks++; if (lat != 8) begin errors++; $display("FAIL exh_latency[%0d]: got %0d expected 8", v, lat); end
    end
    for (int n = 0; n < 40; n++) begin
      longint unsigned v;
      v = longint'($urandom_range(0, 255));
      do_conv(0, v, int'($urandom_range(0, 3)), bcd, ovf, lat, busy);
      exp = ref_bcd(v, 3, eo);
      checks++; if (bcd !== exp || ovf !== eo) begin errors++; $display("FAIL rand_result[%0d]: got %h/%b expected %h/%b", v, bcd, ovf, exp, eo); end
      checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL rand_idle[%0d]: in_ready got %b expected 1", v, ir_a); end
    end
  endtask

  task automatic test_narrow();
    logic [63:0] bcd, exp; logic ovf, eo; int lat; logic busy;
    do_conv(1, 123, 0, bcd, ovf, lat, busy);
    checks++; if (bcd !== 64'h23 || ovf !== 1'b1) begin errors++; $display("FAIL narrow_123: got %h/%b expected 23/1", bcd, ovf); end
    do_conv(1, 99, 0, bcd, ovf, lat, busy);
    checks++; if (bcd !== 64'h99 || ovf !== 1'b0) begin errors++; $display("FAIL narrow_99: got %h/%b expected 99/0", bcd, ovf); end
    do_conv(1, 100, 0, bcd, ovf, lat, busy);
    checks++; if (bcd !== 64'h00 || ovf !== 1'b1) begin errors++; $display("FAIL narrow_100: got %h/%b expected 00/1", bcd, ovf); end
    for (int n = 0; n < 30; n++) begin
      longint unsigned v;
      v = longint'($urandom_range(0, 255));
      do_conv(1, v, int'($urandom_range(0, 2)), bcd, ovf, lat, busy);
      exp = ref_bcd(v, digits_of(1), eo);
      checks++; if (bcd !== exp || ovf !== eo) begin errors++; $display("FAIL narrow_rand[%0d]: got %h/%b expected %h/%b", v, bcd, ovf, exp, eo); end
      checks++; if (lat != bin_w_of(1)) begin errors++; $display("FAIL narrow_latency[%0d]: got %0d expected 8", v, lat); end
    end
  endtask

  task automatic test_wide();
    logic [63:0] bcd, exp; logic ovf, eo; int lat; logic busy;
    do_conv(2, 65535, 0, bcd, ovf, lat, busy);
    checks++; if (bcd !== 64'h65535 || ovf !== 1'b0) begin errors++; $display("FAIL wide_max: got %h/%b expected 65535/0", bcd, ovf); end
    checks++; if (lat != 16) begin errors++; $display("FAIL wide_latency: got %0d expected 16", lat); end
    for (int n = 0; n < 20; n++) begin
      longint unsigned v;
      v = longint'($urandom_range(0, 65535));
      do_conv(2, v, 0, bcd, ovf, lat, busy);
      exp = ref_bcd(v, digits_of(2), eo);
      checks++; if (bcd !== exp || ovf !== eo) begin errors++; $display("FAIL wide_rand[%0d]: got %h/%b expected %h/%b", v, bcd, ovf, exp, eo); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp; logic eo; int lat;
    exp = ref_bcd(200, 3, eo);
    set_en(0, 1'b1, 200);
    tick();
    lat = 0;
    // en stays high with junk data through SHIFT; it must not disturb the conversion.
    while (ov_a !== 1'b1 && lat < 200) begin
      set_en(0, 1'b1, longint'($urandom));
      tick();
      lat++;
    end
    checks++; if (lat != 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", lat); end
    for (int i = 0; i < 20; i++) begin
      set_en(0, 1'(i % 2), longint'($urandom));
      tick();
      checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, ov_a); end
      checks++; if (get_bcd(0) !== exp || of_a !== eo) begin errors++; $display("FAIL bp_stable[%0d]: got %h/%b expected %h/%b", i, get_bcd(0), of_a, exp, eo); end
      checks++; if (ir_a !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, ir_a); end
    end
    set_en(0, 1'b0, 0);
    or_a = 1'b1;
    tick();
    or_a = 1'b0;
    checks++; if (ir_a !== 1'b1 || ov_a !== 1'b0) begin errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", ir_a, ov_a); end
    checks++; if (get_bcd(0) !== exp) begin errors++; $display("FAIL bp_hold_after: got %h expected %h", get_bcd(0), exp); end
    tick();
    checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL bp_no_queue: in_ready got %b expected 1", ir_a); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] bcd; logic ovf; int lat; logic busy;
    set_en(0, 1'b1, 77);
    tick();
    set_en(0, 1'b0, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ir_a !== 1'b1 || ov_a !== 1'b0) begin errors++; $display("FAIL mid_reset_state: in_ready=%b out_valid=%b expected 1/0", ir_a, ov_a); end
    checks++; if (get_bcd(0) !== 64'h0 || of_a !== 1'b0) begin errors++; $display("FAIL mid_reset_bcd: got %h/%b expected 0/0", get_bcd(0), of_a); end
    do_conv(0, 42, 0, bcd, ovf, lat, busy);
    checks++; if (bcd !== 64'h042 || ovf !== 1'b0) begin errors++; $display("FAIL mid_reset_42: got %h/%b expected 042/0", bcd, ovf); end
    checks++; if (lat != 8) begin errors++; $display("FAIL mid_reset_latency: got %0d expected 8", lat); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_max();
    test_back_to_back();
    test_narrow();
    test_wide();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
